// File: rtl/axi_wr_scheduler.sv
// ---------------------------------------------------------------------------
// axi_wr_scheduler
//   Write-path controller for a two-master (m0 = cpu, m1 = dmac) AXI
//   interconnect. It arbitrates AW requests round-robin. Each accepted write
//   is recorded as {master, slave select, AWLEN} in an in-order W routing
//   queue. The W mux is steered from the head of that queue. Completed
//   bursts move to a B routing queue, which steers the B mux.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   m0_aw*/m1_aw* (inputs)    per-master AW valid, address and length
//   awready_i                 AWREADY of the selected slave
//   m0/m1_awgrnt_o, aw_ssel_o AW grant lines and AW slave select
//   wvalid_i/wready_i/wlast_i muxed W handshake and last flag
//   w_active_o, m0/m1_wgrnt_o, w_ssel_o  W route taken from the W queue head
//   bvalid_i/bready_i         muxed B handshake
//   b_active_o, m0/m1_bgrnt_o, b_ssel_o  B route taken from the B queue head
//   outstanding_o             writes accepted on AW whose B has not completed
//   wlast_err_o               sticky: a WLAST disagreed with the beat count
//   wdog_o                    sticky watchdog flag
//
// Optional feature: define WR_WDOG_EN to build the stall watchdog. When the
// macro is undefined, wdog_o is tied to 0.
// ---------------------------------------------------------------------------
module axi_wr_scheduler #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_BITS    = 8,
  parameter int SEL_W       = 4,
  parameter int DEPTH       = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       m0_awvalid_i,
  input  logic [ADDR_WIDTH-1:0]      m0_awaddr_i,
  input  logic [LEN_BITS-1:0]        m0_awlen_i,
  input  logic                       m1_awvalid_i,
  input  logic [ADDR_WIDTH-1:0]      m1_awaddr_i,
  input  logic [LEN_BITS-1:0]        m1_awlen_i,
  input  logic                       awready_i,
  output logic                       m0_awgrnt_o,
  output logic                       m1_awgrnt_o,
  output logic [SEL_W-1:0]           aw_ssel_o,
  input  logic                       wvalid_i,
  input  logic                       wready_i,
  input  logic                       wlast_i,
  output logic                       w_active_o,
  output logic                       m0_wgrnt_o,
  output logic                       m1_wgrnt_o,
  output logic [SEL_W-1:0]           w_ssel_o,
  input  logic                       bvalid_i,
  input  logic                       bready_i,
  output logic                       b_active_o,
  output logic                       m0_bgrnt_o,
  output logic                       m1_bgrnt_o,
  output logic [SEL_W-1:0]           b_ssel_o,
  output logic [$clog2(DEPTH):0]     outstanding_o,
  output logic                       wlast_err_o,
  output logic                       wdog_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BEAT_W = LEN_BITS + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  if (DEPTH < 2 || (1 << PTR_W) != DEPTH) begin : g_bad_depth
    $error("axi_wr_scheduler: DEPTH must be a power of two >= 2");
  end
  if (WDOG_CYCLES < 2) begin : g_bad_wdog
    $error("axi_wr_scheduler: WDOG_CYCLES must be >= 2");
  end

  logic [0:0]          aw_state;
  logic                aw_mst;     // granted master: 0 = m0, 1 = m1
  logic                rr_last;    // last master that completed an AW
  logic [CNT_W-1:0]    outstanding;
  logic                aw_fire;
  logic                aw_req_vld;
  logic [LEN_BITS-1:0] aw_len;
  logic [SEL_W-1:0]    m0_sel;
  logic [SEL_W-1:0]    m1_sel;

  logic                wq_mst [DEPTH];
  logic [SEL_W-1:0]    wq_sel [DEPTH];
  logic [LEN_BITS-1:0] wq_len [DEPTH];
  logic                bq_mst [DEPTH];
  logic [SEL_W-1:0]    bq_sel [DEPTH];
  logic [PTR_W:0]      wq_wr, wq_rd, bq_wr, bq_rd;

  logic [BEAT_W-1:0]   beat;
  logic                w_active, b_active;
  logic                w_head_mst, b_head_mst;
  logic [SEL_W-1:0]    w_head_sel, b_head_sel;
  logic [LEN_BITS-1:0] w_head_len;
  logic                w_last_beat, w_fire, w_pop, b_fire;
  logic                wlast_err;

  // Only the top SEL_W address bits choose the slave.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_awaddr_i[ADDR_WIDTH-SEL_W-1:0],
                              m1_awaddr_i[ADDR_WIDTH-SEL_W-1:0]};

  assign m0_sel = m0_awaddr_i[ADDR_WIDTH-1 -: SEL_W];
  assign m1_sel = m1_awaddr_i[ADDR_WIDTH-1 -: SEL_W];

  // ---- AW arbitration ----
  assign aw_req_vld  = aw_mst ? m1_awvalid_i : m0_awvalid_i;
  assign aw_fire     = (aw_state == ST_GRANT) && aw_req_vld && awready_i;
  assign aw_len      = aw_mst ? m1_awlen_i : m0_awlen_i;
  assign m0_awgrnt_o = (aw_state == ST_GRANT) && !aw_mst;
  assign m1_awgrnt_o = (aw_state == ST_GRANT) && aw_mst;
  assign aw_ssel_o   = (aw_state == ST_GRANT) ? (aw_mst ? m1_sel : m0_sel) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_state <= ST_IDLE;
      aw_mst   <= 1'b0;
      rr_last  <= 1'b1;   // so m0 wins the first two-way contest
    end else begin
      case (aw_state)
        ST_IDLE: begin
          if (outstanding < DEPTH_C && (m0_awvalid_i || m1_awvalid_i)) begin
            aw_state <= ST_GRANT;
            aw_mst   <= (m0_awvalid_i && m1_awvalid_i) ? !rr_last : m1_awvalid_i;
          end
        end
        ST_GRANT: begin
          // A grant is held until its handshake; the return to IDLE
          // forces one idle cycle between grants.
          if (aw_fire) begin
            aw_state <= ST_IDLE;
            rr_last  <= aw_mst;
          end
        end
        default: aw_state <= ST_IDLE;
      endcase
    end
  end

  // ---- W / B routing queues ----
  assign w_active    = (wq_wr != wq_rd);
  assign b_active    = (bq_wr != bq_rd);
  assign w_head_mst  = wq_mst[wq_rd[PTR_W-1:0]];
  assign w_head_sel  = wq_sel[wq_rd[PTR_W-1:0]];
  assign w_head_len  = wq_len[wq_rd[PTR_W-1:0]];
  assign b_head_mst  = bq_mst[bq_rd[PTR_W-1:0]];
  assign b_head_sel  = bq_sel[bq_rd[PTR_W-1:0]];
  assign w_last_beat = (beat == {1'b0, w_head_len});
  assign w_fire      = w_active && wvalid_i && wready_i;
  assign w_pop       = w_fire && w_last_beat;
  assign b_fire      = b_active && bvalid_i && bready_i;

  // Queue payloads are plain storage; reset only clears the pointers, and
  // every route output is gated by its queue's active flag.
  always_ff @(posedge clk_i) begin
    if (aw_fire) begin
      wq_mst[wq_wr[PTR_W-1:0]] <= aw_mst;
      wq_sel[wq_wr[PTR_W-1:0]] <= aw_ssel_o;
      wq_len[wq_wr[PTR_W-1:0]] <= aw_len;
    end
    if (w_pop) begin
      bq_mst[bq_wr[PTR_W-1:0]] <= w_head_mst;
      bq_sel[bq_wr[PTR_W-1:0]] <= w_head_sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wq_wr       <= '0;
      wq_rd       <= '0;
      bq_wr       <= '0;
      bq_rd       <= '0;
      beat        <= '0;
      outstanding <= '0;
      wlast_err   <= 1'b0;
    end else begin
      if (aw_fire) wq_wr <= wq_wr + PTR_ONE;
      if (w_pop) begin
        wq_rd <= wq_rd + PTR_ONE;
        bq_wr <= bq_wr + PTR_ONE;
      end
      if (b_fire) bq_rd <= bq_rd + PTR_ONE;
      // The beat count, not WLAST, decides when a burst ends.
      if (w_fire) begin
        beat <= w_last_beat ? '0 : beat + BEAT_W'(1);
        if (wlast_i != w_last_beat) wlast_err <= 1'b1;
      end
      case ({aw_fire, b_fire})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign w_active_o    = w_active;
  assign m0_wgrnt_o    = w_active && !w_head_mst;
  assign m1_wgrnt_o    = w_active && w_head_mst;
  assign w_ssel_o      = w_active ? w_head_sel : '0;
  assign b_active_o    = b_active;
  assign m0_bgrnt_o    = b_active && !b_head_mst;
  assign m1_bgrnt_o    = b_active && b_head_mst;
  assign b_ssel_o      = b_active ? b_head_sel : '0;
  assign outstanding_o = outstanding;
  assign wlast_err_o   = wlast_err;

`ifdef WR_WDOG_EN
  // Counts cycles in which a route is open but no W/B handshake happens.
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WDOG_CYCLES);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_run;
  logic            wdog;

  assign wd_run = (w_active || b_active) && !w_fire && !b_fire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt <= '0;
      wdog   <= 1'b0;
    end else begin
      if (w_fire || b_fire) begin
        wd_cnt <= '0;
      end else if (wd_run && wd_cnt != WD_LIMIT) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      // Flag rises on the same edge the count reaches the limit.
      if (wd_run && wd_cnt == WD_LIMIT - WD_W'(1)) wdog <= 1'b1;
    end
  end

  assign wdog_o = wdog;
`else
  assign wdog_o = 1'b0;
`endif

endmodule
